// File: rtl/mac_4bit.sv
// Handshaked multiply-accumulate stage: registers 4-bit operand pairs into a
// combinational 4x4 multiplier and presents the sum of every LEN products.

module mult_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] pp [4];

    // Shifted partial products, summed as a balanced two-level tree.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = b[i] ? (8'(a) << i) : 8'd0;
        end
    end

    assign p = (pp[0] + pp[1]) + (pp[2] + pp[3]);

endmodule

module mac_4bit #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       cnt;
    logic [3:0]       a_r;
    logic [3:0]       b_r;
    logic             pv;
    logic             last_r;
    logic [ACC_W-1:0] acc;
    logic             ovf_r;
    logic [7:0]       prod;
    logic [ACC_W:0]   sum_ext;

    logic accept;
    logic group_end;
    logic out_fire;
    logic cnt_wrap;

    mult_4bit u_mult (
        .a (a_r),
        .b (b_r),
        .p (prod)
    );

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (state == ST_ACC);
    assign accept    = in_valid && in_ready;
    assign cnt_wrap  = (cnt == LAST_CNT);
    assign group_end = pv && last_r;
    assign out_fire  = out_valid && out_ready;

    // One extra bit catches the carry-out of each accumulate step.
    assign sum_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};

    // NOTE: every flop below uses non-blocking assignment so all registers
    // update from the same pre-edge values, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= 4'd0;
            b_r    <= 4'd0;
            pv     <= 1'b0;
            cnt    <= 8'd0;
            last_r <= 1'b0;
        end else begin
            pv <= accept;
            if (accept) begin
                a_r <= in_a;
                b_r <= in_b;
                if (cnt_wrap) begin
                    cnt    <= 8'd0;
                    last_r <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else if (group_end) begin
                last_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            ovf_r <= 1'b0;
        end else if (group_end) begin
            acc   <= '0;
            ovf_r <= 1'b0;
        end else if (pv) begin
            acc   <= sum_ext[ACC_W-1:0];
            ovf_r <= ovf_r | sum_ext[ACC_W];
        end
    end

    // The result register is loaded by the final add and held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (group_end) begin
            out_valid <= 1'b1;
            out_sum   <= sum_ext[ACC_W-1:0];
            out_ovf   <= ovf_r | sum_ext[ACC_W];
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:   if (accept && cnt_wrap) state_nxt = ST_FLUSH;
            ST_FLUSH: if (group_end)          state_nxt = ST_HOLD;
            ST_HOLD:  if (out_fire)           state_nxt = ST_ACC;
            default:                          state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

endmodule
